pipe_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It produces every pipeline register's write enable and flush, including `MEM_WBWr` and `MEMWB_Flush` for the MEM/WB register. It also sequences the multi-cycle divider stall and holds a pending PC redirect (exception, `eret`, taken branch) until the instruction cache can accept it. All outputs are combinational from the current inputs and the internal state; the state updates on `posedge clk`.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/CommonDefines.svh | 22 ++
 rtl/div_stall_fsm.sv | 73 +++++++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Default EXE occupancy of a div/divu, in cycles.
    localparam int unsigned DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } div_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redirect_t;

endpackage

// File: rtl/CommonDefines.svh
// Bit positions and constants for the stage write-enable and flush vectors.
`ifndef COMMON_DEFINES_SVH
`define COMMON_DEFINES_SVH

// Write-enable vector: {PC, IFID, IDEXE, EXEMEM, MEMWB}
`define WR_PC     4
`define WR_IFID   3
`define WR_IDEXE  2
`define WR_EXEMEM 1
`define WR_MEMWB  0
`define WR_ALL    5'b11111
`define WR_NONE   5'b00000

// Flush vector: {IFID, IDEXE, EXEMEM, MEMWB}
`define FL_IFID   3
`define FL_IDEXE  2
`define FL_EXEMEM 1
`define FL_MEMWB  0
`define FL_ALL    4'b1111
`define FL_NONE   4'b0000

`endif

// File: rtl/div_stall_fsm.sv
// Sequences the multi-cycle divide stall: counts EXE cycles of a div/divu and
// flags when it may advance.
module div_stall_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic hold,
    input  logic advance,
    output logic Div_Busy,
    output logic div_done
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: abort wins; the counter saturates at DIV_CYCLES
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q == CW'(DIV_CYCLES)) begin
                        state_d = S_DONE;
                    end else if (!hold) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (advance) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign Div_Busy = (state_q == S_DIV);
    assign div_done = (state_q == S_DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: stage enables and flushes by priority, divide
// stall sequencing, and a one-entry pending PC redirect held across I-cache misses.
`include "CommonDefines.svh"

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ICache_Busy,
    input  logic        DCache_Busy,
    input  logic        ID_LoadUse,
    input  logic        EXE_IsDiv,
    input  logic        EXE_BranchTaken,
    input  logic [31:0] EXE_BranchTarget,
    input  logic        MEM_ExceptValid,
    input  logic        MEM_IsEret,
    input  logic [31:0] CP0_RedirectPC,
    output logic        PC_Wr,
    output logic        IFID_Wr,
    output logic        IDEXE_Wr,
    output logic        EXEMEM_Wr,
    output logic        MEM_WBWr,
    output logic        IFID_Flush,
    output logic        IDEXE_Flush,
    output logic        EXEMEM_Flush,
    output logic        MEMWB_Flush,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    output logic        Div_Busy
);

    logic        except;
    logic        div_busy;
    logic        div_done;
    logic        div_start;
    logic        branch_act;
    logic [4:0]  wr;
    logic [3:0]  fl;
    redirect_t   req;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    assign except     = MEM_ExceptValid | MEM_IsEret;
    // A branch only redirects in a cycle where EXE actually advances
    assign branch_act = EXE_BranchTaken & ~except & ~DCache_Busy & ~div_busy;
    assign div_start  = EXE_IsDiv & ~except & ~DCache_Busy;

    div_stall_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_stall_fsm (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (except),
        .hold     (DCache_Busy),
        .advance  (wr[`WR_EXEMEM]),
        .Div_Busy (div_busy),
        .div_done (div_done)
    );

    // New redirect request this cycle; an exception/eret outranks a branch
    always_comb begin
        req = '0;
        if (except) begin
            req.valid = 1'b1;
            req.pc    = CP0_RedirectPC;
        end else if (branch_act) begin
            req.valid = 1'b1;
            req.pc    = EXE_BranchTarget;
        end
    end

    // Enables/flushes by priority, then redirect delivery overrides PC_Wr
    always_comb begin
        wr             = `WR_ALL;
        fl             = `FL_NONE;
        Redirect_Valid = 1'b0;
        Redirect_PC    = '0;
        if (rst) begin
            wr = `WR_NONE;
            fl = `FL_ALL;
        end else begin
            if (except) begin
                fl = `FL_ALL;
            end else if (DCache_Busy) begin
                wr            = `WR_NONE;
                fl[`FL_MEMWB] = 1'b1;
            end else if (div_busy) begin
                wr[`WR_PC]     = 1'b0;
                wr[`WR_IFID]   = 1'b0;
                wr[`WR_IDEXE]  = 1'b0;
                fl[`FL_EXEMEM] = 1'b1;
            end else if (ID_LoadUse) begin
                wr[`WR_PC]    = 1'b0;
                wr[`WR_IFID]  = 1'b0;
                fl[`FL_IDEXE] = 1'b1;
            end else if (ICache_Busy) begin
                wr[`WR_PC]   = 1'b0;
                fl[`FL_IFID] = 1'b1;
            end
            // Squash the wrong-path fetch behind the delay slot
            if (branch_act) begin
                fl[`FL_IFID] = 1'b1;
            end
            if (req.valid) begin
                wr[`WR_PC] = ~ICache_Busy;
                if (!ICache_Busy) begin
                    Redirect_Valid = 1'b1;
                    Redirect_PC    = req.pc;
                end
            end else if (pend_v_q && !ICache_Busy) begin
                wr[`WR_PC]     = 1'b1;
                Redirect_Valid = 1'b1;
                Redirect_PC    = pend_pc_q;
            end
        end
    end

    // Pending redirect: a new request replaces it; it drains when fetch is free
    always_comb begin
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (req.valid) begin
            pend_v_d = ICache_Busy;
            if (ICache_Busy) begin
                pend_pc_d = req.pc;
            end
        end else if (!ICache_Busy) begin
            pend_v_d = 1'b0;
        end
    end

    // Pending redirect register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign PC_Wr        = wr[`WR_PC];
    assign IFID_Wr      = wr[`WR_IFID];
    assign IDEXE_Wr     = wr[`WR_IDEXE];
    assign EXEMEM_Wr    = wr[`WR_EXEMEM];
    assign MEM_WBWr     = wr[`WR_MEMWB];
    assign IFID_Flush   = fl[`FL_IFID];
    assign IDEXE_Flush  = fl[`FL_IDEXE];
    assign EXEMEM_Flush = fl[`FL_EXEMEM];
    assign MEMWB_Flush  = fl[`FL_MEMWB];
    assign Div_Busy     = div_busy & ~rst;

    // The divide is never counting and finished at the same time
    assert property (@(posedge clk) disable iff (rst) !(div_busy && div_done));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// all compared against a behavioural reference model.
module tb_pipe_ctrl;

    localparam int unsigned DIVC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        ICache_Busy, DCache_Busy, ID_LoadUse, EXE_IsDiv, EXE_BranchTaken;
    logic [31:0] EXE_BranchTarget, CP0_RedirectPC;
    logic        MEM_ExceptValid, MEM_IsEret;
    logic        PC_Wr, IFID_Wr, IDEXE_Wr, EXEMEM_Wr, MEM_WBWr;
    logic        IFID_Flush, IDEXE_Flush, EXEMEM_Flush, MEMWB_Flush;
    logic        Redirect_Valid, Div_Busy;
    logic [31:0] Redirect_PC;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ICache_Busy      (ICache_Busy),
        .DCache_Busy      (DCache_Busy),
        .ID_LoadUse       (ID_LoadUse),
        .EXE_IsDiv        (EXE_IsDiv),
        .EXE_BranchTaken  (EXE_BranchTaken),
        .EXE_BranchTarget (EXE_BranchTarget),
        .MEM_ExceptValid  (MEM_ExceptValid),
        .MEM_IsEret       (MEM_IsEret),
        .CP0_RedirectPC   (CP0_RedirectPC),
        .PC_Wr            (PC_Wr),
        .IFID_Wr          (IFID_Wr),
        .IDEXE_Wr         (IDEXE_Wr),
        .EXEMEM_Wr        (EXEMEM_Wr),
        .MEM_WBWr         (MEM_WBWr),
        .IFID_Flush       (IFID_Flush),
        .IDEXE_Flush      (IDEXE_Flush),
        .EXEMEM_Flush     (EXEMEM_Flush),
        .MEMWB_Flush      (MEMWB_Flush),
        .Redirect_Valid   (Redirect_Valid),
        .Redirect_PC      (Redirect_PC),
        .Div_Busy         (Div_Busy)
    );

    typedef struct {
        bit        rst;
        bit        ic;
        bit        dc;
        bit        lu;
        bit        div;
        bit        br;
        bit        exc;
        bit        eret;
        bit [31:0] bt;
        bit [31:0] cp0;
    } stim_t;

    int    n_cmp = 0;
    int    n_err = 0;
    string cur_tag = "init";

    // Reference model: divide phase (0 none, 1 stalling, 2 finished), cycles
    // left before the stall ends, and the pending redirect as a queue of <= 1.
    int        m_phase = 0;
    int        m_left  = 0;
    bit [31:0] m_pend[$];

    // Last observed outputs, for directed length checks
    bit        obs_busy, obs_rv;
    bit [31:0] obs_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        bit        exc, br, busy;
        bit        e_pcw, e_ifw, e_idw, e_exw, e_mww;
        bit        e_fif, e_fid, e_fex, e_fmw, e_rv;
        bit [31:0] e_pc, tgt;
        logic [10:0] got_c, exp_c;

        @(negedge clk);
        rst              = s.rst;
        ICache_Busy      = s.ic;
        DCache_Busy      = s.dc;
        ID_LoadUse       = s.lu;
        EXE_IsDiv        = s.div;
        EXE_BranchTaken  = s.br;
        EXE_BranchTarget = s.bt;
        MEM_ExceptValid  = s.exc;
        MEM_IsEret       = s.eret;
        CP0_RedirectPC   = s.cp0;
        #2;

        exc  = s.exc || s.eret;
        busy = (m_phase == 1);
        br   = s.br && !exc && !s.dc && !busy;
        tgt  = exc ? s.cp0 : s.bt;
        {e_pcw, e_ifw, e_idw, e_exw, e_mww} = 5'b11111;
        {e_fif, e_fid, e_fex, e_fmw}        = 4'b0000;
        e_rv = 1'b0;
        e_pc = '0;
        if (s.rst) begin
            {e_pcw, e_ifw, e_idw, e_exw, e_mww} = 5'b00000;
            {e_fif, e_fid, e_fex, e_fmw}        = 4'b1111;
            busy = 1'b0;
        end else begin
            if (exc) begin
                {e_fif, e_fid, e_fex, e_fmw} = 4'b1111;
            end else if (s.dc) begin
                {e_pcw, e_ifw, e_idw, e_exw, e_mww} = 5'b00000;
                e_fmw = 1'b1;
            end else if (busy) begin
                {e_pcw, e_ifw, e_idw} = 3'b000;
                e_fex = 1'b1;
            end else if (s.lu) begin
                {e_pcw, e_ifw} = 2'b00;
                e_fid = 1'b1;
            end else if (s.ic) begin
                e_pcw = 1'b0;
                e_fif = 1'b1;
            end
            if (br) e_fif = 1'b1;
            if (exc || br) begin
                e_pcw = !s.ic;
                if (!s.ic) begin
                    e_rv = 1'b1;
                    e_pc = tgt;
                end
            end else if (m_pend.size() != 0 && !s.ic) begin
                e_pcw = 1'b1;
                e_rv  = 1'b1;
                e_pc  = m_pend[0];
            end
        end

        got_c = {PC_Wr, IFID_Wr, IDEXE_Wr, EXEMEM_Wr, MEM_WBWr, IFID_Flush, IDEXE_Flush,
                 EXEMEM_Flush, MEMWB_Flush, Redirect_Valid, Div_Busy};
        exp_c = {e_pcw, e_ifw, e_idw, e_exw, e_mww, e_fif, e_fid, e_fex, e_fmw, e_rv, busy};
        check({cur_tag, ":ctrl"}, 64'(got_c), 64'(exp_c));
        check({cur_tag, ":rpc"}, 64'(Redirect_PC), 64'(e_pc));
        obs_busy = Div_Busy;
        obs_rv   = Redirect_Valid;
        obs_pc   = Redirect_PC;

        // Advance the model across the coming clock edge
        if (s.rst) begin
            m_phase = 0;
            m_left  = 0;
            m_pend.delete();
        end else begin
            if (exc || br) begin
                m_pend.delete();
                if (s.ic) m_pend.push_back(tgt);
            end else if (m_pend.size() != 0 && !s.ic) begin
                m_pend.delete();
            end
            if (exc) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (s.div && !s.dc) begin
                    m_phase = 1;
                    m_left  = DIVC - 1;
                end
            end else if (m_phase == 1) begin
                if (m_left == 0) m_phase = 2;
                else if (!s.dc) m_left--;
            end else if (e_exw) begin
                m_phase = 0;
            end
        end
    endtask

    initial begin
        stim_t s;
        int    cnt;
        bit [31:0] seen_pc;

        rst = 1'b1;
        {ICache_Busy, DCache_Busy, ID_LoadUse, EXE_IsDiv, EXE_BranchTaken} = '0;
        {MEM_ExceptValid, MEM_IsEret} = '0;
        EXE_BranchTarget = '0;
        CP0_RedirectPC   = '0;

        cur_tag = "reset";
        s = idle_stim();
        s.rst = 1'b1;
        step(s);
        step(s);
        s = idle_stim();
        step(s);

        cur_tag = "loaduse";
        s = idle_stim();
        s.lu = 1'b1;
        step(s);
        s = idle_stim();
        step(s);

        cur_tag = "div";
        s = idle_stim();
        s.div = 1'b1;
        step(s);
        s = idle_stim();
        cnt = 0;
        for (int i = 0; i < DIVC + 4; i++) begin
            step(s);
            if (obs_busy) cnt++;
        end
        check("div_busy_len", 64'(cnt), 64'(DIVC));

        cur_tag = "branch_pend";
        s = idle_stim();
        s.br = 1'b1;
        s.bt = 32'hBFC0_0100;
        s.ic = 1'b1;
        cnt = 0;
        seen_pc = '0;
        step(s);
        if (obs_rv) cnt++;
        s = idle_stim();
        s.ic = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(s);
            if (obs_rv) cnt++;
        end
        s = idle_stim();
        for (int i = 0; i < 3; i++) begin
            step(s);
            if (obs_rv) begin
                cnt++;
                seen_pc = obs_pc;
            end
        end
        check("branch_rv_count", 64'(cnt), 64'd1);
        check("branch_rv_pc", 64'(seen_pc), 64'h0000_0000_BFC0_0100);

        cur_tag = "div_except";
        s = idle_stim();
        s.div = 1'b1;
        step(s);
        s = idle_stim();
        for (int i = 0; i < 9; i++) step(s);
        s = idle_stim();
        s.exc = 1'b1;
        s.cp0 = 32'hBFC0_0380;
        step(s);
        s = idle_stim();
        step(s);
        check("div_abort_busy", 64'(obs_busy), 64'd0);
        step(s);

        cur_tag = "dcache_lu";
        s = idle_stim();
        s.dc = 1'b1;
        s.lu = 1'b1;
        for (int i = 0; i < 5; i++) step(s);
        s.dc = 1'b0;
        step(s);
        s = idle_stim();
        step(s);

        cur_tag = "rst_mid";
        s = idle_stim();
        s.div = 1'b1;
        step(s);
        s = idle_stim();
        for (int i = 0; i < 4; i++) step(s);
        s.rst = 1'b1;
        step(s);
        s = idle_stim();
        step(s);
        s.br = 1'b1;
        s.bt = 32'h1234_5678;
        s.ic = 1'b1;
        step(s);
        s = idle_stim();
        s.rst = 1'b1;
        s.ic  = 1'b1;
        step(s);
        s = idle_stim();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(s);
            if (obs_rv) cnt++;
        end
        check("no_stale_redirect", 64'(cnt), 64'd0);

        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(199) == 0);
            s.ic   = ($urandom_range(99) < 30);
            s.dc   = ($urandom_range(99) < 15);
            s.lu   = ($urandom_range(99) < 15);
            s.div  = ($urandom_range(99) < 10);
            s.br   = ($urandom_range(99) < 15);
            s.exc  = ($urandom_range(99) < 2);
            s.eret = ($urandom_range(99) < 1);
            s.bt   = $urandom;
            s.cp0  = $urandom;
            step(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
